// File: rtl/debug_run_controller.sv
// ============================================================================
// Module   : debug_run_controller
// Brief    : Debug run/step/halt sequencer and register-dump streamer for the
//            5-stage MIPS pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_run_controller #(
  parameter int              LEN          = 32,
  parameter int              NREGS        = 32,
  parameter int              DRAIN_CYCLES = 4,
  parameter logic [LEN-1:0]  HALT_CODE    = {LEN{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_cmd_valid,
  input  logic [1:0]               in_cmd_code,
  output logic                     out_cmd_ready,
  input  logic [LEN-1:0]           in_instruccion,
  output logic                     out_pipeline_enable,
  output logic                     out_pc_freeze,
  output logic [$clog2(NREGS)-1:0] out_dbg_reg_addr,
  input  logic [LEN-1:0]           in_dbg_reg_data,
  output logic [LEN-1:0]           out_tx_data,
  output logic                     out_tx_valid,
  input  logic                     in_tx_ready,
  output logic                     out_halted,
  output logic [LEN-1:0]           out_cycle_count
);

  localparam int c_ADDR_W  = $clog2(NREGS);
  localparam int c_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_ADDR_W-1:0]  c_ADDR_LAST  = c_ADDR_W'(NREGS - 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] c_CMD_RUN  = 2'b00;
  localparam logic [1:0] c_CMD_STEP = 2'b01;
  localparam logic [1:0] c_CMD_DUMP = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RUN       = 4'd1,
    S_STEP      = 4'd2,
    S_DRAIN     = 4'd3,
    S_HALTED    = 4'd4,
    S_DUMP_REQ  = 4'd5,
    S_DUMP_WAIT = 4'd6,
    S_DUMP_SEND = 4'd7,
    S_DUMP_CNT  = 4'd8
  } state_t;

  state_t                 state_q, state_d;
  logic                   ret_halted_q, ret_halted_d;
  logic [c_DRAIN_W-1:0]   drain_q, drain_d;
  logic [c_ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN-1:0]         data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   en_q, en_d;
  logic                   frz_q, frz_d;
  logic                   halted_q, halted_d;
  logic [LEN-1:0]         cycle_q;

  logic w_cmd_fire;
  logic w_halt_seen;

  assign out_cmd_ready       = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign w_cmd_fire          = in_cmd_valid && out_cmd_ready;
  assign w_halt_seen         = (in_instruccion == HALT_CODE);
  assign out_pipeline_enable = en_q;
  assign out_pc_freeze       = frz_q;
  assign out_dbg_reg_addr    = addr_q;
  assign out_tx_data         = data_q;
  assign out_tx_valid        = valid_q;
  assign out_halted          = halted_q;
  assign out_cycle_count     = cycle_q;

  always_comb begin
    state_d      = state_q;
    ret_halted_d = ret_halted_q;
    drain_d      = drain_q;
    addr_d       = addr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    case (state_q)
      S_IDLE: begin
        if (w_cmd_fire) begin
          case (in_cmd_code)
            c_CMD_RUN:  state_d = S_RUN;
            c_CMD_STEP: state_d = S_STEP;
            c_CMD_DUMP: begin
              state_d      = S_DUMP_REQ;
              ret_halted_d = 1'b0;
              addr_d       = '0;
            end
            default:    state_d = S_IDLE;
          endcase
        end
      end
      // Only a dump can leave HALTED; other commands are swallowed.
      S_HALTED: begin
        if (w_cmd_fire && (in_cmd_code == c_CMD_DUMP)) begin
          state_d      = S_DUMP_REQ;
          ret_halted_d = 1'b1;
          addr_d       = '0;
        end
      end
      S_RUN: begin
        if (w_halt_seen) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_STEP: begin
        state_d = w_halt_seen ? S_DRAIN : S_IDLE;
        drain_d = '0;
      end
      S_DRAIN: begin
        if (drain_q == c_DRAIN_LAST) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else begin
          drain_d = drain_q + c_DRAIN_W'(1);
        end
      end
      S_DUMP_REQ:  state_d = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        data_d  = in_dbg_reg_data;
        valid_d = 1'b1;
        state_d = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        if (in_tx_ready) begin
          if (addr_q == c_ADDR_LAST) begin
            data_d  = cycle_q;
            state_d = S_DUMP_CNT;
          end else begin
            valid_d = 1'b0;
            addr_d  = addr_q + c_ADDR_W'(1);
            state_d = S_DUMP_REQ;
          end
        end
      end
      S_DUMP_CNT: begin
        if (in_tx_ready) begin
          valid_d = 1'b0;
          state_d = ret_halted_q ? S_HALTED : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    en_d  = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
    frz_d = (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ret_halted_q <= 1'b0;
      drain_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      en_q         <= 1'b0;
      frz_q        <= 1'b0;
      halted_q     <= 1'b0;
      cycle_q      <= '0;
    end else begin
      state_q      <= state_d;
      ret_halted_q <= ret_halted_d;
      drain_q      <= drain_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      en_q         <= en_d;
      frz_q        <= frz_d;
      halted_q     <= halted_d;
      if (en_q) begin
        cycle_q <= cycle_q + LEN'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_debug_run_controller.sv
// ============================================================================
// Module   : tb_debug_run_controller
// Brief    : Directed self-checking bench for debug_run_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_cmd_valid;
  logic [1:0]  in_cmd_code;
  logic        out_cmd_ready;
  logic [31:0] in_instruccion;
  logic        out_pipeline_enable;
  logic        out_pc_freeze;
  logic [4:0]  out_dbg_reg_addr;
  logic [31:0] in_dbg_reg_data;
  logic [31:0] out_tx_data;
  logic        out_tx_valid;
  logic        in_tx_ready;
  logic        out_halted;
  logic [31:0] out_cycle_count;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int frz_cnt  = 0;
  int overlap  = 0;
  bit collect  = 1'b0;
  logic [31:0] words[$];
  logic [31:0] regs[32];

  debug_run_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .in_cmd_valid        (in_cmd_valid),
    .in_cmd_code         (in_cmd_code),
    .out_cmd_ready       (out_cmd_ready),
    .in_instruccion      (in_instruccion),
    .out_pipeline_enable (out_pipeline_enable),
    .out_pc_freeze       (out_pc_freeze),
    .out_dbg_reg_addr    (out_dbg_reg_addr),
    .in_dbg_reg_data     (in_dbg_reg_data),
    .out_tx_data         (out_tx_data),
    .out_tx_valid        (out_tx_valid),
    .in_tx_ready         (in_tx_ready),
    .out_halted          (out_halted),
    .out_cycle_count     (out_cycle_count)
  );

  always #5 clk = ~clk;

  // Register file model with a registered debug read port.
  always @(posedge clk) in_dbg_reg_data <= regs[out_dbg_reg_addr];

  always @(negedge clk) begin
    if (out_pipeline_enable) en_cnt++;
    if (out_pc_freeze) frz_cnt++;
    if (out_tx_valid && out_pipeline_enable) overlap++;
    if (collect && out_tx_valid && in_tx_ready) words.push_back(out_tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [1:0] code);
    in_cmd_valid = 1'b1;
    in_cmd_code  = code;
    tick();
    in_cmd_valid = 1'b0;
    in_cmd_code  = 2'b11;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_tx_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_tx_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
    regs[0] = 32'd4;
    regs[1] = 32'd7;
    reset          = 1'b1;
    in_cmd_valid   = 1'b0;
    in_cmd_code    = 2'b11;
    in_instruccion = 32'h0000_0013;
    in_tx_ready    = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b0;

    chk("rst_enable", {31'd0, out_pipeline_enable}, 32'd0);
    chk("rst_freeze", {31'd0, out_pc_freeze}, 32'd0);
    chk("rst_halted", {31'd0, out_halted}, 32'd0);
    chk("rst_valid", {31'd0, out_tx_valid}, 32'd0);
    chk("rst_count", out_cycle_count, 32'd0);
    chk("rst_data", out_tx_data, 32'd0);
    chk("rst_ready", {31'd0, out_cmd_ready}, 32'd1);

    // Reset in the middle of RUN
    send_cmd(2'b00);
    chk("run_enable", {31'd0, out_pipeline_enable}, 32'd1);
    chk("run_not_ready", {31'd0, out_cmd_ready}, 32'd0);
    repeat (3) tick();
    chk("run_count3", out_cycle_count, 32'd3);
    pulse_reset();
    chk("runrst_enable", {31'd0, out_pipeline_enable}, 32'd0);
    chk("runrst_count", out_cycle_count, 32'd0);
    chk("runrst_ready", {31'd0, out_cmd_ready}, 32'd1);

    // Two single steps
    en_cnt = 0;
    send_cmd(2'b01);
    chk("step1_en", {31'd0, out_pipeline_enable}, 32'd1);
    tick();
    chk("step1_off", {31'd0, out_pipeline_enable}, 32'd0);
    send_cmd(2'b01);
    chk("step2_en", {31'd0, out_pipeline_enable}, 32'd1);
    tick();
    chk("step2_off", {31'd0, out_pipeline_enable}, 32'd0);
    chk("step_count", out_cycle_count, 32'd2);
    chk("step_en_cycles", en_cnt, 32'd2);

    // RUN with HALT on the 10th enabled cycle
    pulse_reset();
    en_cnt  = 0;
    frz_cnt = 0;
    send_cmd(2'b00);
    repeat (9) tick();
    in_instruccion = 32'hFFFF_FFFF;
    tick();
    in_instruccion = 32'h0000_0013;
    chk("drain_freeze", {31'd0, out_pc_freeze}, 32'd1);
    chk("drain_enable", {31'd0, out_pipeline_enable}, 32'd1);
    for (int n = 0; n < 10 && !out_halted; n++) tick();
    chk("halt_halted", {31'd0, out_halted}, 32'd1);
    chk("halt_enable", {31'd0, out_pipeline_enable}, 32'd0);
    chk("halt_freeze", {31'd0, out_pc_freeze}, 32'd0);
    chk("halt_count", out_cycle_count, 32'd14);
    chk("halt_freeze_cycles", frz_cnt, 32'd4);
    chk("halt_en_cycles", en_cnt, 32'd14);
    chk("halt_ready", {31'd0, out_cmd_ready}, 32'd1);
    send_cmd(2'b00);
    repeat (3) tick();
    chk("halt_run_ignored_en", {31'd0, out_pipeline_enable}, 32'd0);
    chk("halt_run_ignored_cnt", out_cycle_count, 32'd14);
    chk("halt_still", {31'd0, out_halted}, 32'd1);

    // Full dump with transmitter always ready
    in_tx_ready = 1'b1;
    overlap = 0;
    words.delete();
    collect = 1'b1;
    send_cmd(2'b10);
    for (int n = 0; n < 300 && words.size() < 33; n++) tick();
    collect = 1'b0;
    tick();
    chk("dump_words", words.size(), 32'd33);
    if (words.size() == 33) begin
      for (int i = 0; i < 32; i++) chk($sformatf("dump_r%0d", i), words[i], regs[i]);
      chk("dump_count_word", words[32], 32'd14);
    end
    chk("dump_overlap", overlap, 32'd0);
    chk("dump_ret_halted", {31'd0, out_halted}, 32'd1);
    chk("dump_ret_ready", {31'd0, out_cmd_ready}, 32'd1);
    chk("dump_ret_valid", {31'd0, out_tx_valid}, 32'd0);

    // Dump with backpressure on word 1
    in_tx_ready = 1'b0;
    send_cmd(2'b10);
    wait_valid("bp_w0");
    chk("bp_w0_data", out_tx_data, 32'd4);
    chk("bp_w0_addr", {27'd0, out_dbg_reg_addr}, 32'd0);
    in_tx_ready = 1'b1;
    tick();
    in_tx_ready = 1'b0;
    chk("bp_gap_valid", {31'd0, out_tx_valid}, 32'd0);
    wait_valid("bp_w1");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {31'd0, out_tx_valid}, 32'd1);
      chk("bp_hold_data", out_tx_data, 32'd7);
      chk("bp_hold_addr", {27'd0, out_dbg_reg_addr}, 32'd1);
      tick();
    end
    in_tx_ready = 1'b1;
    for (int n = 0; n < 200 && !out_cmd_ready; n++) tick();
    chk("bp_done_ready", {31'd0, out_cmd_ready}, 32'd1);
    chk("bp_done_valid", {31'd0, out_tx_valid}, 32'd0);
    chk("bp_done_overlap", overlap, 32'd0);

    // Counter wrap
    pulse_reset();
    force dut.cycle_q = 32'hFFFF_FFFE;
    tick();
    release dut.cycle_q;
    chk("wrap_preset", out_cycle_count, 32'hFFFF_FFFE);
    repeat (3) begin
      send_cmd(2'b01);
      tick();
    end
    chk("wrap_count", out_cycle_count, 32'd1);

    // Reset while a word is pending
    in_tx_ready = 1'b0;
    send_cmd(2'b10);
    wait_valid("rstdump");
    chk("rstdump_valid_pre", {31'd0, out_tx_valid}, 32'd1);
    pulse_reset();
    chk("rstdump_valid", {31'd0, out_tx_valid}, 32'd0);
    chk("rstdump_ready", {31'd0, out_cmd_ready}, 32'd1);
    chk("rstdump_count", out_cycle_count, 32'd0);
    tick();
    chk("rstdump_valid_after", {31'd0, out_tx_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
